// File: rtl/regwb_pkg.sv
// regwb_pkg: shared widths, write-back entry type and constants for the
// register-file write-port arbiter (regwb_arb) and its result FIFO.
package regwb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One buffered port-B result: destination register and data.
  // The destination field is named wreg because "reg" is a reserved word.
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: small synchronous FIFO of wb_entry_t holding port-B results.
// The head entry is visible combinationally so the arbiter can drain it in
// the same cycle it decides the write slot is free. Pointers wrap modulo DEPTH.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  wb_entry_t     din,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  // Status flags, guarded push/pop and head read.
  always_comb begin
    full    = (count_reg == CW'(DEPTH));
    empty   = (count_reg == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    count   = count_reg;
    head    = mem[rd_ptr_reg];
  end

  // Storage array: written on push, no reset needed for the payload.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/regwb_arb.sv
// regwb_arb: shares the register file's single write port between the
// pipeline writeback (port A, fixed priority) and a buffered multi-cycle
// result port (port B), and keeps a pending-write scoreboard for decode.
// Optional feature: define REGWB_STARVE_GUARD_EN to enable the starvation
// guard that requests a WB bubble when port B waits MAX_WAIT cycles.
module regwb_arb
  import regwb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_reg,
  input  logic [REG_W-1:0]  chk_reg1,
  input  logic [REG_W-1:0]  chk_reg2,
  input  logic [REG_W-1:0]  chk_reg3,
  output logic              hazard,
  output logic              starve_stall,
  output logic              regwrite,
  output logic [REG_W-1:0]  wrreg,
  output logic [DATA_W-1:0] wrdata
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          a_slot;
  logic          drain;
  logic          push;
  wb_entry_t     din;
  wb_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   pend_reg;
  logic [31:0]   pend_next;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  regwb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (drain),
    .din   (din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write-slot arbitration: port A wins unless it targets r0; otherwise drain the FIFO head.
  always_comb begin
    a_slot   = a_we && (a_reg != REG_ZERO);
    drain    = rst_n && !a_slot && !fifo_empty;
    b_ready  = rst_n && (fifo_count < CW'(FIFO_DEPTH));
    push     = b_valid && b_ready && !fifo_full && (b_reg != REG_ZERO);
    din.wreg = b_reg;
    din.data = b_data;
    regwrite = 1'b0;
    wrreg    = REG_ZERO;
    wrdata   = '0;
    if (rst_n && a_slot) begin
      regwrite = 1'b1;
      wrreg    = a_reg;
      wrdata   = a_data;
    end else if (drain) begin
      regwrite = 1'b1;
      wrreg    = head.wreg;
      wrdata   = head.data;
    end
  end

  // Scoreboard next state: issue sets, drain clears, set wins; r0 never pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_reg != REG_ZERO)) begin
      set_mask[iss_reg] = 1'b1;
    end
    if (drain) begin
      clr_mask[head.wreg] = 1'b1;
    end
    pend_next = ((pend_reg & ~clr_mask) | set_mask) & ~32'd1;
    hazard    = pend_reg[chk_reg1] | pend_reg[chk_reg2] | pend_reg[chk_reg3];
  end

  // Registered pending-write bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

`ifdef REGWB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_reg;
  logic [WW-1:0] wait_next;
  logic          starve_reg;

  // Count consecutive undrained cycles with a non-empty FIFO, saturating at MAX_WAIT.
  always_comb begin
    if (fifo_empty || drain) begin
      wait_next = '0;
    end else if (wait_reg < WW'(MAX_WAIT)) begin
      wait_next = wait_reg + WW'(1);
    end else begin
      wait_next = wait_reg;
    end
  end

  // Wait counter and registered bubble request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_reg   <= '0;
      starve_reg <= 1'b0;
    end else begin
      wait_reg   <= wait_next;
      starve_reg <= (wait_next >= WW'(MAX_WAIT));
    end
  end

  assign starve_stall = starve_reg;
`else
  assign starve_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regwb_arb.sv
// tb_regwb_arb: directed scenarios plus randomized traffic for regwb_arb,
// checked every cycle against a queue/bit-array model of the arbiter rules.
module tb_regwb_arb;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic        clk;
  logic        rst_n;
  logic        a_we;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic [4:0]  chk_reg3;
  logic        hazard;
  logic        starve_stall;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;

  int total = 0;
  int bad   = 0;

  regwb_arb #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_we         (a_we),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .iss_valid    (iss_valid),
    .iss_reg      (iss_reg),
    .chk_reg1     (chk_reg1),
    .chk_reg2     (chk_reg2),
    .chk_reg3     (chk_reg3),
    .hazard       (hazard),
    .starve_stall (starve_stall),
    .regwrite     (regwrite),
    .wrreg        (wrreg),
    .wrdata       (wrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t       q[$];
  bit   [31:0] pend_m = '0;
  int         wait_m = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reset empties the model immediately, like the asynchronous DUT reset.
  always @(negedge rst_n) begin
    q.delete();
    pend_m = '0;
    wait_m = 0;
  end

  // Advance the model at each active edge from the inputs held over the cycle.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      bit   a_own;
      bit   drn;
      bit   acc;
      int   sz;
      ent_t e;
      a_own = a_we && (a_reg != 0);
      sz    = q.size();
      drn   = !a_own && (sz > 0);
      acc   = b_valid && (sz < DEPTH);
      if (drn) begin
        e = q.pop_front();
        pend_m[e.r] = 1'b0;
      end
      if (acc && b_reg != 0) q.push_back('{r: b_reg, d: b_data});
      if (iss_valid && iss_reg != 0) pend_m[iss_reg] = 1'b1;
      if (sz > 0 && !drn) wait_m++;
      else wait_m = 0;
    end
  end

  // Single compare process: outputs checked mid low-phase every cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n !== 1'b1) begin
      chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
      chk("rst_hazard", {31'd0, hazard}, 32'd0);
      chk("rst_starve", {31'd0, starve_stall}, 32'd0);
    end else begin
      bit       a_own;
      bit       drn;
      bit       exp_rw;
      bit       exp_hz;
      bit       exp_st;
      a_own  = a_we && (a_reg != 0);
      drn    = !a_own && (q.size() > 0);
      exp_rw = a_own || drn;
      exp_hz = pend_m[chk_reg1] | pend_m[chk_reg2] | pend_m[chk_reg3];
`ifdef REGWB_STARVE_GUARD_EN
      exp_st = (wait_m >= MAXW);
`else
      exp_st = 1'b0;
`endif
      if (a_own && pend_m[a_reg]) begin
        bad++;
        $display("FAIL protocol: port A writes pending reg %0d at %0t", a_reg, $time);
      end
      chk("regwrite", {31'd0, regwrite}, {31'd0, exp_rw});
      chk("b_ready", {31'd0, b_ready}, {31'd0, (q.size() < DEPTH)});
      chk("hazard", {31'd0, hazard}, {31'd0, exp_hz});
      chk("starve_stall", {31'd0, starve_stall}, {31'd0, exp_st});
      if (exp_rw) begin
        chk("wrreg", {27'd0, wrreg}, {27'd0, (a_own ? a_reg : q[0].r)});
        chk("wrdata", wrdata, (a_own ? a_data : q[0].d));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    a_we = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    iss_valid = 0; iss_reg = 0;
    chk_reg1 = 0; chk_reg2 = 0; chk_reg3 = 0;
  endtask

  task automatic go();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) go();
    #3;
    chk("lit_reset_b_ready", {31'd0, b_ready}, 32'd0);
    chk("lit_reset_regwrite", {31'd0, regwrite}, 32'd0);
    go(); rst_n = 1'b1;
    #3;
    chk("lit_post_reset_b_ready", {31'd0, b_ready}, 32'd1);

    // Port A only
    go(); a_we = 1; a_reg = 8; a_data = 32'hDEADBEEF;
    #3;
    chk("lit_a_regwrite", {31'd0, regwrite}, 32'd1);
    chk("lit_a_wrreg", {27'd0, wrreg}, 32'd8);
    chk("lit_a_wrdata", wrdata, 32'hDEADBEEF);
    $display("txn: port A write r8");

    // Port B with free slot
    go(); idle(); iss_valid = 1; iss_reg = 9; chk_reg1 = 9;
    go(); iss_valid = 0; b_valid = 1; b_reg = 9; b_data = 32'h12345678;
    #3;
    chk("lit_b_hazard_set", {31'd0, hazard}, 32'd1);
    go(); b_valid = 0;
    #3;
    chk("lit_b_wrreg", {27'd0, wrreg}, 32'd9);
    chk("lit_b_wrdata", wrdata, 32'h12345678);
    go();
    #3;
    chk("lit_b_hazard_clear", {31'd0, hazard}, 32'd0);
    $display("txn: port B write r9");

    // Contention
    go(); a_we = 1; a_reg = 10; a_data = 32'hA0; b_valid = 1; b_reg = 11; b_data = 32'hB11;
    go(); b_reg = 12; b_data = 32'hB12;
    go(); b_valid = 0;
    #3;
    chk("lit_cont_b_ready", {31'd0, b_ready}, 32'd0);
    chk("lit_cont_a_wrreg", {27'd0, wrreg}, 32'd10);
    go(); a_we = 0;
    #3;
    chk("lit_cont_first", {27'd0, wrreg}, 32'd11);
    go();
    #3;
    chk("lit_cont_second", {27'd0, wrreg}, 32'd12);
    go();
    #3;
    chk("lit_cont_idle", {31'd0, regwrite}, 32'd0);
    $display("txn: contention r11 r12");

    // Zero-register handling
    go(); b_valid = 1; b_reg = 0; b_data = 32'hFFFF;
    go(); b_reg = 13; b_data = 32'hC13;
    #3;
    chk("lit_zero_dropped", {31'd0, regwrite}, 32'd0);
    go(); b_valid = 0; a_we = 1; a_reg = 0; a_data = 32'h5555;
    #3;
    chk("lit_zero_slot_wrreg", {27'd0, wrreg}, 32'd13);
    chk("lit_zero_slot_wrdata", wrdata, 32'hC13);
    go(); idle();
    #3;
    chk("lit_zero_idle", {31'd0, regwrite}, 32'd0);
    $display("txn: zero-register handling");

    // Starvation guard
    go(); a_we = 1; a_reg = 10; a_data = 32'hA1; b_valid = 1; b_reg = 14; b_data = 32'hE14;
    go(); b_valid = 0;
    go(); go(); go();
    #3;
    chk("lit_starve_before", {31'd0, starve_stall}, 32'd0);
    go(); a_we = 0;
    #3;
`ifdef REGWB_STARVE_GUARD_EN
    chk("lit_starve_on", {31'd0, starve_stall}, 32'd1);
`else
    chk("lit_starve_off", {31'd0, starve_stall}, 32'd0);
`endif
    chk("lit_starve_drain", {27'd0, wrreg}, 32'd14);
    go();
    #3;
    chk("lit_starve_release", {31'd0, starve_stall}, 32'd0);
    $display("txn: starvation scenario");

    // Reset mid-operation
    go(); idle(); chk_reg1 = 9; iss_valid = 1; iss_reg = 9;
    a_we = 1; a_reg = 10; b_valid = 1; b_reg = 15; b_data = 32'hF15;
    go(); iss_valid = 0; b_reg = 16; b_data = 32'hF16;
    go(); b_valid = 0;
    #3;
    chk("lit_mid_hazard", {31'd0, hazard}, 32'd1);
    chk("lit_mid_full", {31'd0, b_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("lit_mid_rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("lit_mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("lit_mid_rst_hazard", {31'd0, hazard}, 32'd0);
    go(); go();
    rst_n = 1'b1; a_we = 0;
    #3;
    chk("lit_mid_rel_b_ready", {31'd0, b_ready}, 32'd1);
    chk("lit_mid_rel_regwrite", {31'd0, regwrite}, 32'd0);
    go();
    #3;
    chk("lit_mid_no_stale", {31'd0, regwrite}, 32'd0);
    $display("txn: reset mid-operation");

    // Randomized traffic, with phases of heavy port-A load
    for (int i = 0; i < 3000; i++) begin
      int a_pct;
      logic [4:0] r;
      go();
      a_pct = (((i / 200) % 2) == 1) ? 92 : 45;
      rst_n = ($urandom_range(0, 499) != 0);
      r = 5'($urandom_range(0, 31));
      a_we = ($urandom_range(0, 99) < a_pct);
      if (pend_m[r]) a_we = 0;
      a_reg = r;
      a_data = $urandom;
      b_valid = ($urandom_range(0, 99) < 40);
      b_reg = 5'($urandom_range(0, 31));
      b_data = $urandom;
      iss_valid = ($urandom_range(0, 99) < 25);
      iss_reg = 5'($urandom_range(0, 31));
      chk_reg1 = 5'($urandom_range(0, 31));
      chk_reg2 = 5'($urandom_range(0, 31));
      chk_reg3 = 5'($urandom_range(0, 31));
    end
    go(); rst_n = 1'b1; idle();
    go();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
